// File: rtl/pifregs_if.sv
// XI/XO bus bundle for pifregs: registered write/read-control inputs from the
// XI front end, readback byte and board outputs back toward it.
interface pifregs_if #(
  parameter int AW      = 8,
  parameter int SAW     = 4,
  parameter int DW      = 6,
  parameter int MISC_W  = 3,
  parameter int PULSE_W = 4
) ();
  // No valid/ready here: XI_PWr and XI_PRdFinished are single-cycle strobes
  // that the front end asserts for exactly one cycle and that are always
  // accepted; reads are continuous and XO is a plain registered value.
  logic               XI_PWr;
  logic [AW-1:0]      XI_PRWA;
  logic               XI_PRdFinished;
  logic [SAW-1:0]     XI_PRdSubA;
  logic [DW-1:0]      XI_PD;
  logic [7:0]         XO;
  logic [MISC_W-1:0]  MiscReg;
  logic [PULSE_W-1:0] Pulse;

  modport master (
    output XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD,
    input  XO, MiscReg, Pulse
  );

  modport slave (
    input  XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD,
    output XO, MiscReg, Pulse
  );
endinterface

// File: rtl/pifregs.sv
// PIF control registers (scratch, misc/LED, self-clearing pulse) with a fixed
// five-stage ID readback pipeline. Optional write counter: PIFREGS_WRCNT_EN.
module pifregs #(
  parameter int                  AW           = 8,
  parameter int                  SAW          = 4,
  parameter int                  DW           = 6,
  parameter int                  NSCRATCH     = 4,
  parameter int                  MISC_W       = 3,
  parameter int                  PULSE_W      = 4,
  parameter logic [AW-1:0]       A_SCRATCH    = 'h02,
  parameter logic [AW-1:0]       A_MISC       = 'h01,
  parameter logic [AW-1:0]       A_PULSE      = 'h0A,
  parameter logic [AW-1:0]       A_ID         = 'h00,
  parameter logic [7:0]          ID_VAL       = 8'h41,
  parameter logic [DW-1:0]       SCRATCH_INIT = 'h15,
  parameter logic [MISC_W-1:0]   MISC_INIT    = '0
) (
  input  logic       xclk,
  input  logic       xrst_n,
  pifregs_if.slave   bus
);
  localparam int             NSUB     = NSCRATCH + 3;
  localparam logic [SAW:0]   NSUB_W   = (SAW+1)'(NSUB);
  localparam logic [SAW-1:0] OFF_LAST = SAW'(NSUB - 1);

  logic [DW-1:0]      scratch [NSCRATCH];
  logic [MISC_W-1:0]  misc;
  logic [MISC_W-1:0]  misc_out;
  logic [PULSE_W-1:0] pulse;
  logic [SAW-1:0]     offset;

  logic [SAW-1:0]     s1_sub;
  logic               s1_flag;
  logic [7:0]         s2_data;
  logic               s2_flag;
  logic [7:0]         s3_data;
  logic [7:0]         s4_data;
  logic [7:0]         xo;

  logic               id_sel;
  logic               wr_misc;
  logic               wr_pulse;
  logic               wr_scratch;
  logic [SAW:0]       sub_sum;
  logic [SAW-1:0]     sub_eff;
  logic [7:0]         status;
  logic [7:0]         map_data;

  always_comb begin
    id_sel     = (bus.XI_PRWA == A_ID);
    wr_misc    = bus.XI_PWr && (bus.XI_PRWA == A_MISC);
    wr_pulse   = bus.XI_PWr && (bus.XI_PRWA == A_PULSE);
    wr_scratch = 1'b0;
    for (int i = 0; i < NSCRATCH; i++) begin
      if (bus.XI_PWr && (bus.XI_PRWA == A_SCRATCH + AW'(i))) wr_scratch = 1'b1;
    end
    sub_sum = {1'b0, bus.XI_PRdSubA} + {1'b0, offset};
    sub_eff = SAW'(sub_sum % NSUB_W);
  end

`ifdef PIFREGS_WRCNT_EN
  logic [7:0] wr_cnt;

  // Clearing via a write to A_ID takes priority over counting.
  always_ff @(posedge xclk) begin
    if (!xrst_n) begin
      wr_cnt <= 8'h00;
    end else if (bus.XI_PWr && id_sel) begin
      wr_cnt <= 8'h00;
    end else if ((wr_scratch || wr_misc || wr_pulse) && (wr_cnt != 8'hFF)) begin
      wr_cnt <= wr_cnt + 8'd1;
    end
  end

  always_comb status = wr_cnt;
`else
  always_comb status = 8'h60 | {4'h0, s1_sub[3:0]};
`endif

  always_ff @(posedge xclk) begin
    if (!xrst_n) begin
      for (int i = 0; i < NSCRATCH; i++) scratch[i] <= SCRATCH_INIT;
      misc     <= MISC_INIT;
      misc_out <= MISC_INIT;
      pulse    <= '0;
    end else begin
      for (int i = 0; i < NSCRATCH; i++) begin
        if (bus.XI_PWr && (bus.XI_PRWA == A_SCRATCH + AW'(i))) scratch[i] <= bus.XI_PD;
      end
      if (wr_misc) misc <= bus.XI_PD[MISC_W-1:0];
      misc_out <= misc;
      pulse    <= wr_pulse ? bus.XI_PD[PULSE_W-1:0] : '0;
    end
  end

  // Leaving the ID address resets the burst; that beats an increment.
  always_ff @(posedge xclk) begin
    if (!xrst_n) begin
      offset <= '0;
    end else if (!id_sel) begin
      offset <= '0;
    end else if (bus.XI_PRdFinished) begin
      offset <= (offset == OFF_LAST) ? '0 : offset + SAW'(1);
    end
  end

  always_comb begin
    map_data = 8'h00;
    if (s1_sub == '0) map_data = ID_VAL;
    for (int i = 0; i < NSCRATCH; i++) begin
      if (s1_sub == SAW'(i + 1)) map_data = 8'h40 | 8'(scratch[i]);
    end
    if (s1_sub == SAW'(NSCRATCH + 1)) map_data = 8'h50 | 8'(misc);
    if (s1_sub == SAW'(NSCRATCH + 2)) map_data = status;
  end

  always_ff @(posedge xclk) begin
    if (!xrst_n) begin
      s1_sub  <= '0;
      s1_flag <= 1'b0;
      s2_data <= 8'h00;
      s2_flag <= 1'b0;
      s3_data <= 8'h00;
      s4_data <= 8'h00;
      xo      <= 8'h00;
    end else begin
      s1_sub  <= sub_eff;
      s1_flag <= id_sel;
      s2_data <= map_data;
      s2_flag <= s1_flag;
      s3_data <= s2_flag ? s2_data : 8'h00;
      s4_data <= s3_data;
      xo      <= s4_data;
    end
  end

  assign bus.XO      = xo;
  assign bus.MiscReg = misc_out;
  assign bus.Pulse   = pulse;
endmodule

// File: tb/tb_pifregs.sv
// Self-checking bench for pifregs: a behavioural register/queue model predicts
// XO, Pulse and MiscReg; directed scenarios also compare to fixed values.
module tb_pifregs;
  logic xclk;
  logic xrst_n;

  pifregs_if bus ();

  pifregs dut (
    .xclk   (xclk),
    .xrst_n (xrst_n),
    .bus    (bus)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

`ifdef PIFREGS_WRCNT_EN
  localparam logic [7:0] STATUS_RST = 8'h00;
  localparam logic [7:0] STATUS_ONE = 8'h01;
`else
  localparam logic [7:0] STATUS_RST = 8'h66;
  localparam logic [7:0] STATUS_ONE = 8'h66;
`endif

  // reference model state
  logic [5:0] m_scratch [4];
  logic [2:0] m_misc;
  int         m_off;
  int         m_cnt;
  logic [7:0] exp_q [$];
  logic [7:0] exp_xo;
  logic [3:0] exp_pulse;
  logic [2:0] exp_misc;

  int total;
  int bad;

  logic [7:0] rst_tab [7];
  logic [7:0] addr_tab [12];

  function automatic logic [7:0] ref_read(input int s);
    if (s == 0) return 8'h41;
    if (s <= 4) return 8'h40 + 8'(m_scratch[s-1]);
    if (s == 5) return 8'h50 + 8'(m_misc);
`ifdef PIFREGS_WRCNT_EN
    return 8'(m_cnt);
`else
    return 8'h60 + 8'(s);
`endif
  endfunction

  // One clock of stimulus; the model predicts outputs after the edge.
  task automatic step(input logic pwr, input logic [7:0] addr, input logic fin,
                      input logic [3:0] suba, input logic [5:0] pd);
    int         s;
    logic       counted;
    logic [2:0] misc_old;
    bus.XI_PWr         = pwr;
    bus.XI_PRWA        = addr;
    bus.XI_PRdFinished = fin;
    bus.XI_PRdSubA     = suba;
    bus.XI_PD          = pd;
    s        = (int'(suba) + m_off) % 7;
    misc_old = m_misc;
    counted  = 1'b0;
    exp_pulse = 4'h0;
    if (pwr) begin
      if (addr >= 8'h02 && addr <= 8'h05) begin
        m_scratch[int'(addr) - 2] = pd;
        counted = 1'b1;
      end else if (addr == 8'h01) begin
        m_misc  = pd[2:0];
        counted = 1'b1;
      end else if (addr == 8'h0A) begin
        exp_pulse = pd[3:0];
        counted   = 1'b1;
      end else if (addr == 8'h00) begin
        m_cnt = 0;
      end
      if (counted && m_cnt < 255) m_cnt++;
    end
    exp_q.push_back((addr == 8'h00) ? ref_read(s) : 8'h00);
    if (addr != 8'h00) m_off = 0;
    else if (fin) m_off = (m_off + 1) % 7;
    exp_misc = misc_old;
    @(posedge xclk);
    #1;
    exp_xo = exp_q.pop_front();
  endtask

  task automatic do_reset();
    bus.XI_PWr         = 1'b0;
    bus.XI_PRWA        = 8'h05;
    bus.XI_PRdFinished = 1'b0;
    bus.XI_PRdSubA     = 4'h0;
    bus.XI_PD          = 6'h00;
    xrst_n = 1'b0;
    @(posedge xclk);
    #1;
    xrst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_scratch[i] = 6'h15;
    m_misc = 3'b000;
    m_off  = 0;
    m_cnt  = 0;
    exp_q.delete();
    repeat (4) exp_q.push_back(8'h00);
    exp_xo    = 8'h00;
    exp_pulse = 4'h0;
    exp_misc  = 3'b000;
  endtask

  task automatic test_reset();
    do_reset();
    if (bus.XO !== 8'h00) begin bad++; $display("FAIL reset_xo got=%h exp=00", bus.XO); end
    total++;
    if (bus.MiscReg !== 3'b000) begin bad++; $display("FAIL reset_misc got=%h exp=0", bus.MiscReg); end
    total++;
    if (bus.Pulse !== 4'h0) begin bad++; $display("FAIL reset_pulse got=%h exp=0", bus.Pulse); end
    total++;
    for (int j = 0; j < 11; j++) begin
      if (j < 7) step(1'b0, 8'h00, 1'b0, 4'(j), 6'h00);
      else step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
      if (bus.XO !== exp_xo) begin bad++; $display("FAIL reset_read_model j=%0d got=%h exp=%h", j, bus.XO, exp_xo); end
      total++;
      if (j < 4) begin
        if (bus.XO !== 8'h00) begin bad++; $display("FAIL reset_xo_idle j=%0d got=%h exp=00", j, bus.XO); end
        total++;
      end else begin
        if (bus.XO !== rst_tab[j-4]) begin bad++; $display("FAIL reset_read_sub%0d got=%h exp=%h", j-4, bus.XO, rst_tab[j-4]); end
        total++;
      end
    end
  endtask

  task automatic test_scratch_write();
    logic [7:0] tab [4];
    tab = '{8'h55, 8'h55, 8'h6A, 8'h55};
    step(1'b1, 8'h04, 1'b0, 4'h0, 6'h2A);
    for (int j = 0; j < 8; j++) begin
      if (j < 4) step(1'b0, 8'h00, 1'b0, 4'(j + 1), 6'h00);
      else step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
      if (bus.XO !== exp_xo) begin bad++; $display("FAIL scratch_model j=%0d got=%h exp=%h", j, bus.XO, exp_xo); end
      total++;
      if (j >= 4) begin
        if (bus.XO !== tab[j-4]) begin bad++; $display("FAIL scratch_sub%0d got=%h exp=%h", j-3, bus.XO, tab[j-4]); end
        total++;
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] tab [10];
    tab = '{8'h55, 8'h50, STATUS_ONE, 8'h41, 8'h55, 8'h55, 8'h6A, 8'h55, 8'h00, 8'h55};
    for (int j = 0; j < 14; j++) begin
      if (j < 8) step(1'b0, 8'h00, 1'b1, 4'h4, 6'h00);
      else if (j == 8) step(1'b0, 8'h05, 1'b0, 4'h4, 6'h00);
      else if (j == 9) step(1'b0, 8'h00, 1'b0, 4'h4, 6'h00);
      else step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
      if (bus.XO !== exp_xo) begin bad++; $display("FAIL burst_model j=%0d got=%h exp=%h", j, bus.XO, exp_xo); end
      total++;
      if (j >= 4) begin
        if (bus.XO !== tab[j-4]) begin bad++; $display("FAIL burst_seq k=%0d got=%h exp=%h", j-4, bus.XO, tab[j-4]); end
        total++;
      end
    end
  endtask

  task automatic test_pulse_misc();
    logic [3:0] ptab [3];
    ptab = '{4'h9, 4'h9, 4'h0};
    for (int j = 0; j < 3; j++) begin
      if (j < 2) step(1'b1, 8'h0A, 1'b0, 4'h0, 6'h09);
      else step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
      if (bus.Pulse !== ptab[j]) begin bad++; $display("FAIL pulse j=%0d got=%h exp=%h", j, bus.Pulse, ptab[j]); end
      total++;
      if (bus.Pulse !== exp_pulse) begin bad++; $display("FAIL pulse_model j=%0d got=%h exp=%h", j, bus.Pulse, exp_pulse); end
      total++;
    end
    step(1'b1, 8'h01, 1'b0, 4'h0, 6'h05);
    if (bus.MiscReg !== 3'b000) begin bad++; $display("FAIL misc_early got=%h exp=0", bus.MiscReg); end
    total++;
    step(1'b0, 8'h00, 1'b0, 4'h5, 6'h00);
    if (bus.MiscReg !== 3'b101) begin bad++; $display("FAIL misc_late got=%h exp=5", bus.MiscReg); end
    total++;
    repeat (4) step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
    if (bus.XO !== 8'h55) begin bad++; $display("FAIL misc_read got=%h exp=55", bus.XO); end
    total++;
    if (bus.XO !== exp_xo) begin bad++; $display("FAIL misc_read_model got=%h exp=%h", bus.XO, exp_xo); end
    total++;
  endtask

`ifdef PIFREGS_WRCNT_EN
  task automatic test_wrcnt();
    logic [7:0] addrs [3];
    logic [7:0] want  [3];
    addrs = '{8'h02, 8'h00, 8'h7F};
    want  = '{8'hFF, 8'h00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        for (int n = 0; n < 300; n++) step(1'b1, 8'h02, 1'b0, 4'h0, 6'($urandom_range(0, 63)));
      end else begin
        step(1'b1, addrs[k], 1'b0, 4'h0, 6'h11);
      end
      step(1'b0, 8'h00, 1'b0, 4'h6, 6'h00);
      repeat (4) step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
      if (bus.XO !== want[k]) begin bad++; $display("FAIL wrcnt k=%0d got=%h exp=%h", k, bus.XO, want[k]); end
      total++;
      if (bus.XO !== exp_xo) begin bad++; $display("FAIL wrcnt_model k=%0d got=%h exp=%h", k, bus.XO, exp_xo); end
      total++;
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 400; n++) begin
      a = addr_tab[$urandom_range(0, 11)];
      if (a == 8'hEE) a = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
      if (bus.XO !== exp_xo) begin bad++; $display("FAIL rand_xo n=%0d got=%h exp=%h", n, bus.XO, exp_xo); end
      total++;
      if (bus.Pulse !== exp_pulse) begin bad++; $display("FAIL rand_pulse n=%0d got=%h exp=%h", n, bus.Pulse, exp_pulse); end
      total++;
      if (bus.MiscReg !== exp_misc) begin bad++; $display("FAIL rand_misc n=%0d got=%h exp=%h", n, bus.MiscReg, exp_misc); end
      total++;
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h03, 1'b0, 4'h0, 6'h3F);
    step(1'b1, 8'h01, 1'b0, 4'h0, 6'h07);
    for (int j = 0; j < 3; j++) step(1'b0, 8'h00, 1'b1, 4'(j + 1), 6'h00);
    do_reset();
    if (bus.XO !== 8'h00) begin bad++; $display("FAIL midrst_xo got=%h exp=00", bus.XO); end
    total++;
    if (bus.MiscReg !== 3'b000) begin bad++; $display("FAIL midrst_misc got=%h exp=0", bus.MiscReg); end
    total++;
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
      if (bus.XO !== 8'h00) begin bad++; $display("FAIL midrst_flush j=%0d got=%h exp=00", j, bus.XO); end
      total++;
    end
    for (int j = 0; j < 11; j++) begin
      if (j < 7) step(1'b0, 8'h00, 1'b0, 4'(j), 6'h00);
      else step(1'b0, 8'h05, 1'b0, 4'h0, 6'h00);
      if (j >= 4) begin
        if (bus.XO !== rst_tab[j-4]) begin bad++; $display("FAIL midrst_sub%0d got=%h exp=%h", j-4, bus.XO, rst_tab[j-4]); end
        total++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_tab  = '{8'h41, 8'h55, 8'h55, 8'h55, 8'h55, 8'h50, STATUS_RST};
    addr_tab = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                 8'h0A, 8'h7F, 8'h06, 8'hEE};
    xrst_n             = 1'b0;
    bus.XI_PWr         = 1'b0;
    bus.XI_PRWA        = 8'h00;
    bus.XI_PRdFinished = 1'b0;
    bus.XI_PRdSubA     = 4'h0;
    bus.XI_PD          = 6'h00;
    repeat (2) @(posedge xclk);
    #1;
    test_reset();
    test_scratch_write();
    test_burst();
    test_pulse_misc();
`ifdef PIFREGS_WRCNT_EN
    test_wrcnt();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
